pipeline_wb_stage: RTL and testbench

//  Registered MEM/WB boundary plus writeback select for the 5-stage RV32I pipeline.
//  - Captures MEM-stage results and formats sub-word loads (LB/LH/LW/LBU/LHU).
//  - Selects writeback data: ALU, load, PC+4 or U-type immediate.
//  - Waits for late data-memory responses, stalling upstream until the data arrives.
//  - Drives the register-file write port and the WB forwarding source.

---
 rtl/pipeline_wb_stage_pkg.sv | 24 ++
 rtl/pipeline_wb_stage_if.sv | 28 ++
 rtl/pipeline_wb_stage_load_formatter.sv | 33 +++
 rtl/pipeline_wb_stage.sv | 141 ++++++++++++++
 tb/tb_pipeline_wb_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_wb_stage_pkg.sv
// Shared constants for the MEM/WB boundary: writeback select codes,
// RV32I load funct3 encodings and the writeback FSM state encodings.
package pipeline_wb_stage_pkg;

    localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4  = 2'b10;
    localparam logic [1:0] MEMTOREG_IMM  = 2'b11;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [0:0] WB_RUN  = 1'b0;
    localparam logic [0:0] WB_WAIT = 1'b1;

    // True when the writeback select takes its data from memory
    function automatic logic is_load_sel(input logic [1:0] memtoreg);
        return memtoreg == MEMTOREG_LOAD;
    endfunction

endpackage

// File: rtl/pipeline_wb_stage_if.sv
// MEM-stage result bundle plus the data-memory read response, as seen
// by the writeback stage. The MEM side drives, the WB stage consumes.
interface pipeline_wb_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               valid_MEM;
    logic               RegWrite_MEM;
    logic [RADDR_W-1:0] rd_MEM;
    logic [1:0]         MemtoReg_MEM;
    logic [2:0]         funct3_MEM;
    logic [1:0]         addr_lo_MEM;
    logic [XLEN-1:0]    ALU_MEM;
    logic [XLEN-1:0]    PC4_MEM;
    logic [XLEN-1:0]    imm_MEM;
    logic [XLEN-1:0]    dmem_rdata;
    logic               dmem_rvalid;

    modport master (
        output valid_MEM, RegWrite_MEM, rd_MEM, MemtoReg_MEM, funct3_MEM,
               addr_lo_MEM, ALU_MEM, PC4_MEM, imm_MEM, dmem_rdata, dmem_rvalid
    );

    modport slave (
        input  valid_MEM, RegWrite_MEM, rd_MEM, MemtoReg_MEM, funct3_MEM,
               addr_lo_MEM, ALU_MEM, PC4_MEM, imm_MEM, dmem_rdata, dmem_rvalid
    );
endinterface

// File: rtl/pipeline_wb_stage_load_formatter.sv
// Combinational sub-word load extraction: picks the byte/half addressed
// by the low address bits and sign- or zero-extends it. Undefined funct3
// codes produce zero. Misaligned halfwords are not trapped: off[0] is ignored.
module load_formatter
    import pipeline_wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/half and apply the extension for funct3
    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        data     = '0;
        case (funct3)
            FUNCT3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            FUNCT3_LH:  data = {{(XLEN-16){half_sel[15]}}, half_sel};
            FUNCT3_LW:  data = word;
            FUNCT3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            FUNCT3_LHU: data = {{(XLEN-16){1'b0}}, half_sel};
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_wb_stage.sv
// MEM/WB pipeline register and writeback select for the RV32I pipeline.
// A captured load whose data has not arrived parks the stage in WAIT and
// raises wb_busy until dmem_rvalid delivers the word.
// Optional feature: define WB_INSTRET_EN to build the retired-instruction
// counter on the instret port; otherwise instret is tied to zero.
module pipeline_wb_stage
    import pipeline_wb_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic                 flush_in,
    pipeline_wb_stage_if.slave   mem,
    output logic [XLEN-1:0]      Data_out_WB,
    output logic [RADDR_W-1:0]   rd_WB,
    output logic                 RegWrite_WB,
    output logic                 wb_busy,
    output logic [CNT_W-1:0]     instret
);

    logic [0:0]         state_q;
    logic               valid_q;
    logic               regwrite_q;
    logic [RADDR_W-1:0] rd_q;
    logic [1:0]         memtoreg_q;
    logic [2:0]         funct3_q;
    logic [1:0]         addr_lo_q;
    logic [XLEN-1:0]    alu_q;
    logic [XLEN-1:0]    pc4_q;
    logic [XLEN-1:0]    imm_q;
    logic [XLEN-1:0]    word_q;
    logic               retired_q;

    logic               capture;
    logic               retire;
    logic               wait_start;
    logic [XLEN-1:0]    load_data;

    assign wb_busy    = (state_q == WB_WAIT);
    assign capture    = !stall_in && !wb_busy;
    assign wait_start = capture && mem.valid_MEM && !flush_in
                        && is_load_sel(mem.MemtoReg_MEM) && !mem.dmem_rvalid;

    // A slot retires in its first RUN cycle only, so a slot held by
    // stall_in writes the register file and counts exactly once.
    assign retire      = valid_q && (state_q == WB_RUN) && !retired_q;
    assign RegWrite_WB = retire && regwrite_q && (rd_q != '0);
    assign rd_WB       = rd_q;

    load_formatter #(.XLEN(XLEN)) u_load_formatter (
        .word   (word_q),
        .off    (addr_lo_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // MEM/WB pipeline register; the memory word is also latched on a late response
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            memtoreg_q <= MEMTOREG_ALU;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            word_q     <= '0;
        end else if (capture) begin
            valid_q    <= mem.valid_MEM && !flush_in;
            regwrite_q <= mem.RegWrite_MEM;
            rd_q       <= mem.rd_MEM;
            memtoreg_q <= mem.MemtoReg_MEM;
            funct3_q   <= mem.funct3_MEM;
            addr_lo_q  <= mem.addr_lo_MEM;
            alu_q      <= mem.ALU_MEM;
            pc4_q      <= mem.PC4_MEM;
            imm_q      <= mem.imm_MEM;
            word_q     <= mem.dmem_rdata;
        end else if (wb_busy && mem.dmem_rvalid) begin
            word_q     <= mem.dmem_rdata;
        end
    end

    // RUN/WAIT sequencing for late data-memory responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_RUN;
        end else begin
            case (state_q)
                WB_RUN:  if (wait_start) state_q <= WB_WAIT;
                WB_WAIT: if (mem.dmem_rvalid) state_q <= WB_RUN;
                default: state_q <= WB_RUN;
            endcase
        end
    end

    // Marks the held slot as already retired until a new slot is captured
    always_ff @(posedge clk) begin
        if (rst || capture) begin
            retired_q <= 1'b0;
        end else if (retire) begin
            retired_q <= 1'b1;
        end
    end

    // Writeback data select; bubbles are still muxed but never written
    always_comb begin
        Data_out_WB = alu_q;
        case (memtoreg_q)
            MEMTOREG_ALU:  Data_out_WB = alu_q;
            MEMTOREG_LOAD: Data_out_WB = load_data;
            MEMTOREG_PC4:  Data_out_WB = pc4_q;
            MEMTOREG_IMM:  Data_out_WB = imm_q;
            default:       Data_out_WB = alu_q;
        endcase
    end

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    // Retired-instruction counter, one count per retiring slot, wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Self-checking bench for pipeline_wb_stage: directed cases followed by
// randomized transactions compared against a transaction-level model.
module tb_pipeline_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] Data_out_WB;
    logic [4:0]  rd_WB;
    logic        RegWrite_WB;
    logic        wb_busy;
    logic [63:0] instret;

    pipeline_wb_stage_if #(.XLEN(32), .RADDR_W(5)) mem_bus ();

    pipeline_wb_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .mem         (mem_bus),
        .Data_out_WB (Data_out_WB),
        .rd_WB       (rd_WB),
        .RegWrite_WB (RegWrite_WB),
        .wb_busy     (wb_busy),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    int unsigned     n_vec = 0;
    int unsigned     n_err = 0;
    longint unsigned retired_cnt = 0;
    logic [31:0]     shown_data = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] instret_ref();
`ifdef WB_INSTRET_EN
        return retired_cnt;
`else
        return 64'd0;
`endif
    endfunction

    // Reference writeback value from the RV32I load/select rules
    function automatic logic [31:0] model_data(input logic [1:0] m2r, input logic [2:0] f3,
                                               input logic [1:0] off, input logic [31:0] alu,
                                               input logic [31:0] pc4, input logic [31:0] imm,
                                               input logic [31:0] word);
        longint unsigned b, h;
        b = (longint'(word) >> (8 * int'(off))) & 64'hFF;
        h = (longint'(word) >> (16 * (int'(off) / 2))) & 64'hFFFF;
        case (m2r)
            2'd0: return alu;
            2'd2: return pc4;
            2'd3: return imm;
            default: begin
                case (f3)
                    3'd0: return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
                    3'd1: return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
                    3'd2: return word;
                    3'd4: return 32'(b);
                    3'd5: return 32'(h);
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    task automatic drive_fields(input logic v, input logic rw, input logic [4:0] rd,
                                input logic [1:0] m2r, input logic [2:0] f3, input logic [1:0] off,
                                input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm);
        mem_bus.valid_MEM    = v;
        mem_bus.RegWrite_MEM = rw;
        mem_bus.rd_MEM       = rd;
        mem_bus.MemtoReg_MEM = m2r;
        mem_bus.funct3_MEM   = f3;
        mem_bus.addr_lo_MEM  = off;
        mem_bus.ALU_MEM      = alu;
        mem_bus.PC4_MEM      = pc4;
        mem_bus.imm_MEM      = imm;
    endtask

    task automatic drive_junk();
        drive_fields(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
                     2'($urandom), $urandom, $urandom, $urandom);
        mem_bus.dmem_rdata = $urandom;
    endtask

    // One instruction through WB: optional stall cycles, capture, optional late data
    task automatic run_txn(input logic v, input logic rw, input logic [4:0] rd,
                           input logic [1:0] m2r, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                           input logic [31:0] word, input int unsigned late, input logic fl,
                           input int unsigned nstall);
        logic        waits;
        logic [31:0] cap_word;
        logic [31:0] exp;
        waits = v && !fl && (m2r == 2'b01) && (late != 0);
        for (int unsigned k = 0; k < nstall; k++) begin
            drive_fields(v, rw, rd, m2r, f3, off, alu, pc4, imm);
            stall_in            = 1'b1;
            flush_in            = 1'($urandom);
            mem_bus.dmem_rvalid = 1'($urandom);
            mem_bus.dmem_rdata  = $urandom;
            @(posedge clk); #1;
            check("stall_we", 64'(RegWrite_WB), 64'd0);
            check("stall_hold", 64'(Data_out_WB), 64'(shown_data));
        end
        drive_fields(v, rw, rd, m2r, f3, off, alu, pc4, imm);
        stall_in = 1'b0;
        flush_in = fl;
        if (late != 0) begin
            mem_bus.dmem_rvalid = 1'b0;
            cap_word            = $urandom;
        end else begin
            mem_bus.dmem_rvalid = 1'b1;
            cap_word            = word;
        end
        mem_bus.dmem_rdata = cap_word;
        @(posedge clk); #1;
        if (waits) begin
            for (int unsigned i = 0; i < late; i++) begin
                check("wait_busy", 64'(wb_busy), 64'd1);
                check("wait_we", 64'(RegWrite_WB), 64'd0);
                drive_junk();
                stall_in = 1'($urandom);
                flush_in = 1'($urandom);
                if (i == late - 1) begin
                    mem_bus.dmem_rvalid = 1'b1;
                    mem_bus.dmem_rdata  = word;
                end else begin
                    mem_bus.dmem_rvalid = 1'b0;
                end
                @(posedge clk); #1;
            end
            cap_word = word;
        end
        exp = model_data(m2r, f3, off, alu, pc4, imm, cap_word);
        check("busy", 64'(wb_busy), 64'd0);
        check("data", 64'(Data_out_WB), 64'(exp));
        check("rd", 64'(rd_WB), 64'(rd));
        check("we", 64'(RegWrite_WB), 64'(v && !fl && rw && (rd != 5'd0)));
        check("instret", instret, instret_ref());
        if (v && !fl) retired_cnt++;
        shown_data          = exp;
        stall_in            = 1'b0;
        flush_in            = 1'b0;
        mem_bus.dmem_rvalid = 1'b0;
    endtask

    initial begin
        logic [63:0] exp10;
        rst      = 1'b1;
        stall_in = 1'b0;
        flush_in = 1'b0;
        drive_fields(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, '0, '0, '0);
        mem_bus.dmem_rdata  = '0;
        mem_bus.dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_data", 64'(Data_out_WB), 64'd0);
        check("rst_rd", 64'(rd_WB), 64'd0);
        check("rst_we", 64'(RegWrite_WB), 64'd0);
        check("rst_busy", 64'(wb_busy), 64'd0);
        check("rst_instret", instret, 64'd0);
        rst = 1'b0;

        // Directed cases
        run_txn(1, 1, 5'd5, 2'b00, 3'd0, 2'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        run_txn(1, 1, 5'd6, 2'b01, 3'b000, 2'd3, 32'h3, 32'h0, 32'h0, 32'h80FF_FF7F, 0, 0, 2);
        check("lb_sext", 64'(shown_data), 64'hFFFF_FF80);
        run_txn(1, 1, 5'd7, 2'b01, 3'b100, 2'd3, 32'h3, 32'h0, 32'h0, 32'h80FF_FF7F, 0, 0, 1);
        check("lbu_zext", 64'(shown_data), 64'h80);
        run_txn(1, 1, 5'd8, 2'b01, 3'b001, 2'd2, 32'h2, 32'h0, 32'h0, 32'h8001_0000, 3, 0, 0);
        check("lh_late", 64'(shown_data), 64'hFFFF_8001);
        run_txn(1, 1, 5'd9, 2'b11, 3'd0, 2'd0, 32'h0, 32'h0, 32'hABCD_E000, 32'h0, 0, 0, 1);
        run_txn(1, 1, 5'd10, 2'b10, 3'd0, 2'd0, 32'h0, 32'h104, 32'h0, 32'h0, 0, 0, 0);
        run_txn(1, 1, 5'd0, 2'b00, 3'd0, 2'd0, 32'h55, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        run_txn(1, 1, 5'd11, 2'b00, 3'd0, 2'd0, 32'h66, 32'h0, 32'h0, 32'h0, 0, 1, 0);
        run_txn(1, 1, 5'd12, 2'b01, 3'b011, 2'd1, 32'h1, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);

        // Reset while a late load is pending
        drive_fields(1, 1, 5'd13, 2'b01, 3'b010, 2'd0, '0, '0, '0);
        mem_bus.dmem_rvalid = 1'b0;
        mem_bus.dmem_rdata  = $urandom;
        @(posedge clk); #1;
        check("rstwait_busy", 64'(wb_busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstwait_busy0", 64'(wb_busy), 64'd0);
        check("rstwait_we", 64'(RegWrite_WB), 64'd0);
        check("rstwait_data", 64'(Data_out_WB), 64'd0);
        check("rstwait_instret", instret, 64'd0);
        rst         = 1'b0;
        retired_cnt = 0;
        shown_data  = '0;

        // Ten retirements from a clean count
        for (int i = 0; i < 10; i++)
            run_txn(1, 1, 5'(i + 1), 2'b00, 3'd0, 2'd0, $urandom, 32'h0, 32'h0, 32'h0, 0, 0,
                    $urandom_range(0, 1));
        drive_junk();
        stall_in = 1'b1;
        @(posedge clk); #1;
`ifdef WB_INSTRET_EN
        exp10 = 64'd10;
`else
        exp10 = 64'd0;
`endif
        check("instret10", instret, exp10);
        stall_in = 1'b0;

        // Randomized transactions
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  m2r;
            int unsigned late;
            m2r  = 2'($urandom);
            late = (m2r == 2'b01 && $urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
            run_txn(1'($urandom_range(0, 7) != 0), 1'($urandom), 5'($urandom), m2r,
                    3'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
                    late, 1'($urandom_range(0, 5) == 0), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
